wiphy_dac_pack: RTL

//  Converts the wiphy transmit AXI-stream (one IQ sample per beat) into

---
 rtl/wiphy_dac_pack.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/wiphy_dac_pack.sv
// wiphy_dac_pack
//   Packs the wiphy transmit AXI-stream (one IQ sample per beat) into
//   multi-channel DAC frames. Enabled channels are filled in ascending index
//   order. Completed frames are queued in a first-word-fall-through FIFO and
//   presented on a valid/ready DAC port. DAC underruns are counted with
//   saturation and raise a sticky interrupt.
// Ports
//   clk, reset          single clock, asynchronous active-high reset
//   enable              run control (0: packer idle, partial frame dropped)
//   ch_enable           per-channel enable mask, latched at frame start
//   s_axis_tvalid/tdata/tready  sample input, I=[SW-1:0], Q=[2SW-1:SW]
//   dac_valid/ready/data        frame output, channel c at [c*2SW +: 2SW]
//   underrun_clear      pulse clearing underrun_count and irq
//   underrun_count      saturating 16-bit underrun counter
//   irq                 sticky underrun interrupt
module wiphy_dac_pack #(
  parameter int NUM_CHANNELS = 2,
  parameter int SAMPLE_WIDTH = 16,
  parameter int DEPTH        = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  enable,
  input  logic [NUM_CHANNELS-1:0]               ch_enable,
  input  logic                                  s_axis_tvalid,
  input  logic [2*SAMPLE_WIDTH-1:0]             s_axis_tdata,
  output logic                                  s_axis_tready,
  output logic                                  dac_valid,
  input  logic                                  dac_ready,
  output logic [NUM_CHANNELS*2*SAMPLE_WIDTH-1:0] dac_data,
  input  logic                                  underrun_clear,
  output logic [15:0]                           underrun_count,
  output logic                                  irq
);

  localparam int BW = 2 * SAMPLE_WIDTH;
  localparam int FW = NUM_CHANNELS * BW;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  function automatic logic [NUM_CHANNELS-1:0] lowest_set(input logic [NUM_CHANNELS-1:0] v);
    lowest_set = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (v[i] && (lowest_set == '0)) lowest_set[i] = 1'b1;
    end
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [NUM_CHANNELS-1:0] mask_q, mask_d, filled_q, filled_d, mask_eff, sel;
  logic [FW-1:0]           asm_q, asm_d, frame_w;
  logic                    at_first, accept, complete, push, pop, empty;
  logic [AW-1:0]           wr_q, rd_q;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    full_q;
  logic [FW-1:0]           mem [DEPTH];
  logic [15:0]             ucnt_q, ucnt_d;
  logic                    irq_q, irq_d, underrun_ev;

  // Packer: no channel filled yet means we sit at the first slot, where the
  // live ch_enable is used and latched so a mid-frame mask change waits.
  assign at_first      = (filled_q == '0);
  assign mask_eff      = at_first ? ch_enable : mask_q;
  assign s_axis_tready = ~reset & enable & (|mask_eff) & ~full_q;
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign sel           = lowest_set(mask_eff & ~filled_q);
  assign complete      = ((filled_q | sel) == mask_eff);
  assign push          = accept & complete;

  always_comb begin
    frame_w = asm_q;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (sel[c]) frame_w[c*BW +: BW] = s_axis_tdata;
    end
  end

  always_comb begin
    mask_d   = mask_q;
    filled_d = filled_q;
    asm_d    = asm_q;
    if (!enable) begin
      filled_d = '0;
      asm_d    = '0;
    end else if (accept) begin
      if (at_first) mask_d = ch_enable;
      if (complete) begin
        filled_d = '0;
        asm_d    = '0;
      end else begin
        filled_d = filled_q | sel;
        asm_d    = frame_w;
      end
    end
  end

  // Frame FIFO: occupancy counter spans 0..DEPTH, pointers wrap naturally.
  assign empty     = (cnt_q == '0);
  assign pop       = dac_ready & ~empty;
  assign dac_valid = ~empty;
  assign dac_data  = empty ? '0 : mem[rd_q];

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (pop && !push) cnt_d = cnt_q - CW'(1);
  end

  // Underruns: clear wins over history but not over an event in the same cycle.
  assign underrun_ev = enable & dac_ready & empty;

  always_comb begin
    ucnt_d = ucnt_q;
    irq_d  = irq_q;
    if (underrun_clear) begin
      ucnt_d = {15'd0, underrun_ev};
      irq_d  = underrun_ev;
    end else if (underrun_ev) begin
      ucnt_d = sat_inc(ucnt_q);
      irq_d  = 1'b1;
    end
  end

  assign underrun_count = ucnt_q;
  assign irq            = irq_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q   <= '0;
      filled_q <= '0;
      asm_q    <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      ucnt_q   <= '0;
      irq_q    <= 1'b0;
    end else begin
      mask_q   <= mask_d;
      filled_q <= filled_d;
      asm_q    <= asm_d;
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      cnt_q    <= cnt_d;
      full_q   <= (cnt_d == CW'(DEPTH));
      ucnt_q   <= ucnt_d;
      irq_q    <= irq_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= frame_w;
  end

endmodule
